nn_sequencer: RTL and testbench
===============================

// Module: nn_sequencer
// PURPOSE
//  Program sequencer for NeuralNetwork. It fetches instruction words from a program ROM/RAM,
//  decodes them, and drives the controller's instruction, address and flag inputs, one issue per cycle.
//  Optional hardware repeat with address auto-increment; stalls on datapath backpressure.
//  Replaces the bench-forced controller inputs with a self-running program flow.
// PARAMETERS
//  PC_W      10   program address width (program depth 2**PC_W words)
//  ADDR_W    16   width of every data-memory address field
//  RPT_W      8   repeat-count field width
//  IW        64   instruction word width = 4(op)+3*ADDR_W+RPT_W+4(flags)
// PORTS
//  clk            in   1       system clock
//  reset          in   1       async, active-low; 0 = in reset
//  start          in   1       pulse; begins execution at pc_start (sampled in IDLE/HALTED only)
//  pc_start       in   PC_W    first program address
//  stall          in   1       datapath not ready; hold current issue
//  prog_rd_en     out  1       program memory read strobe
//  prog_addr      out  PC_W    program memory address
//  prog_data      in   IW      read data, valid exactly 1 cycle after prog_rd_en
//  instruction    out  inst_t  opcode to controller; INST_NOP when not issuing
//  issue_valid    out  1       instruction/fields valid this cycle
//  xy_read_addr   out  ADDR_W  per mapping table; 0 when unused
//  xy_write_addr  out  ADDR_W
//  w_read_addr    out  ADDR_W
//  w_write_addr   out  ADDR_W
//  mac_addr       out  ADDR_W
//  act_bypass, act_mask, xy_acc_loopback, xy_acc_op  out 1 each; flags[3:0] of word
//  busy           out  1       high in FETCH/LOAD/ISSUE
//  halted         out  1       high in HALTED
//  error          out  1       sticky; unknown opcode seen; cleared by start
// BEHAVIOUR
//  Word: [63:60] op, [59:44] A, [43:28] B, [27:12] C, [11:4] rpt, [3:0] {bypass,mask,loopback,op}.
//  Reset: state=IDLE, pc=0, all outputs 0 except instruction=INST_NOP.
//  FSM: IDLE -start-> FETCH (pc<=pc_start, error<=0); FETCH: prog_rd_en=1, prog_addr=pc -> LOAD;
//   LOAD: latch prog_data into IR, cnt<=0; op==HALT -> HALTED; unknown op -> error<=1, HALTED; else -> ISSUE.
//   ISSUE: issue_valid=1; outputs come from the IR regs (no comb path from prog_data);
//    if !stall: if cnt==max(rpt,1)-1 then pc<=pc+1 (wraps mod 2**PC_W), go FETCH;
//    else cnt++, each USED address field +1 (mod 2**ADDR_W).
//   Stall holds every output and cnt unchanged.
//   HALTED -start-> FETCH; start in other states ignored.
//  Latency: first issue 2 cycles after entering FETCH; per-instruction cost = 2 + max(rpt,1) cycles
//   when no stalls. rpt=0 issues exactly once.
//  Mapping (unlisted outputs = 0):
//   MATMUL: xy_rd=A, w_rd=B | ACCMOV: xy_wr=A | LOADMAC: xy_rd=A, mac=B
//   MATMULT: w_rd=A, xy_rd=B, xy_wr=C | VECTTOMAT: xy_rd=A, w_wr=B
//   WCONSTPROD: xy_rd=A, w_rd=B | WACC: w_rd=A, w_wr=B | NOP: issued once, fields 0
//  Flags are driven only for ACCMOV/MATMULT; 0 otherwise.
//  Async reset mid-ISSUE: outputs go to reset values immediately; the in-flight instruction is dropped.
// STRUCTURE
//  definitions pkg: seq_word_t packed struct (fields above), seq_state_t enum {IDLE,FETCH,LOAD,ISSUE,HALTED},
//   SEQ_IW constant; opcode codes stay the existing INST_* / inst_t.
//  Sub-module seq_decode (combinational): IR -> mapped addresses, used-field mask, flags, legal bit.
// TESTING
//  1 prog[4]={MATMUL,A=4,B=4,rpt=0}, prog[5]=HALT, start pc_start=4 -> 1 issue: xy_rd=4, w_rd=4;
//    then halted=1 at cycle 5 after start.
//  2 {MATMULT,A=8,B=2,C=16,rpt=3,flags=4'b1100} -> 3 consecutive issues: (w8,x2,y16),(9,3,17),(10,4,18);
//    bypass=mask=1 on each.
//  3 Same as 2 with stall high for 2 cycles on the 2nd issue -> (9,3,17) held 3 cycles; total issues still 3.
//  4 pc_start=1023 with word{ACCMOV,A=7}, prog[0]=HALT -> issue xy_wr=7, then fetch addr 0, halted.
//  5 Opcode 4'hF -> error=1, halted=1, no issue_valid; a new start clears error.
//  6 Drive reset low during ISSUE of a rpt=5 op -> issue_valid=0, instruction=INST_NOP in the same cycle.
//    After reset is released, state is IDLE until the next start.

Source files
------------

// File: rtl/nn_sequencer_pkg.sv
// Shared definitions for the NeuralNetwork program sequencer: opcodes, the
// instruction word layout, FSM states and the address-bump helper.
package nn_sequencer_pkg;

  localparam int PC_W   = 10;
  localparam int ADDR_W = 16;
  localparam int RPT_W  = 8;
  localparam int SEQ_IW = 4 + 3 * ADDR_W + RPT_W + 4;

  // Bit positions inside the used-field mask produced by the decoder
  localparam int USE_XY_RD = 0;
  localparam int USE_XY_WR = 1;
  localparam int USE_W_RD  = 2;
  localparam int USE_W_WR  = 3;
  localparam int USE_MAC   = 4;

  typedef enum logic [3:0] {
    INST_NOP        = 4'h0,
    INST_MATMUL     = 4'h1,
    INST_ACCMOV     = 4'h2,
    INST_LOADMAC    = 4'h3,
    INST_MATMULT    = 4'h4,
    INST_VECTTOMAT  = 4'h5,
    INST_WCONSTPROD = 4'h6,
    INST_WACC       = 4'h7,
    INST_HALT       = 4'h8
  } inst_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] c;
    logic [RPT_W-1:0]  rpt;
    logic              bypass;
    logic              mask;
    logic              loopback;
    logic              acc_op;
  } seq_word_t;

  typedef struct packed {
    logic [ADDR_W-1:0] xy_rd;
    logic [ADDR_W-1:0] xy_wr;
    logic [ADDR_W-1:0] w_rd;
    logic [ADDR_W-1:0] w_wr;
    logic [ADDR_W-1:0] mac;
  } seq_addr_t;

  localparam seq_addr_t ADDR_NONE = {(5 * ADDR_W){1'b0}};

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, HALTED} seq_state_t;

  function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] addr, input logic en);
    return addr + {{(ADDR_W - 1){1'b0}}, en};
  endfunction

endpackage

// File: rtl/nn_sequencer_if.sv
// Program-memory and controller-issue bus between the sequencer (master)
// and the memory/controller side (slave).
interface nn_sequencer_if;

  logic                                 prog_rd_en;
  logic [nn_sequencer_pkg::PC_W-1:0]    prog_addr;
  logic [nn_sequencer_pkg::SEQ_IW-1:0]  prog_data;
  logic                                 stall;
  nn_sequencer_pkg::inst_t              instruction;
  logic                                 issue_valid;
  logic [nn_sequencer_pkg::ADDR_W-1:0]  xy_read_addr;
  logic [nn_sequencer_pkg::ADDR_W-1:0]  xy_write_addr;
  logic [nn_sequencer_pkg::ADDR_W-1:0]  w_read_addr;
  logic [nn_sequencer_pkg::ADDR_W-1:0]  w_write_addr;
  logic [nn_sequencer_pkg::ADDR_W-1:0]  mac_addr;
  logic                                 act_bypass;
  logic                                 act_mask;
  logic                                 xy_acc_loopback;
  logic                                 xy_acc_op;

  modport master (
    output prog_rd_en, prog_addr, instruction, issue_valid,
           xy_read_addr, xy_write_addr, w_read_addr, w_write_addr, mac_addr,
           act_bypass, act_mask, xy_acc_loopback, xy_acc_op,
    input  prog_data, stall
  );

  modport slave (
    input  prog_rd_en, prog_addr, instruction, issue_valid,
           xy_read_addr, xy_write_addr, w_read_addr, w_write_addr, mac_addr,
           act_bypass, act_mask, xy_acc_loopback, xy_acc_op,
    output prog_data, stall
  );

endinterface

// File: rtl/nn_sequencer_decode.sv
// Combinational decode of a program word into controller address mapping,
// the set of fields that auto-increment on repeat, flags and legality.
module nn_sequencer_decode
  import nn_sequencer_pkg::*;
(
  input  seq_word_t        word,
  output inst_t            inst,
  output seq_addr_t        addr,
  output logic [4:0]       used,
  output logic [3:0]       flags,
  output logic [RPT_W-1:0] last_cnt,
  output logic             legal,
  output logic             is_halt
);

  // Opcode mapping table; unknown opcodes leave legal low.
  always_comb begin
    inst    = INST_NOP;
    addr    = ADDR_NONE;
    used    = 5'b00000;
    flags   = 4'b0000;
    legal   = 1'b1;
    is_halt = 1'b0;
    case (inst_t'(word.op))
      INST_NOP: begin
        inst = INST_NOP;
      end
      INST_MATMUL, INST_WCONSTPROD: begin
        inst       = inst_t'(word.op);
        addr.xy_rd = word.a;
        addr.w_rd  = word.b;
        used       = 5'b00101;
      end
      INST_ACCMOV: begin
        inst       = INST_ACCMOV;
        addr.xy_wr = word.a;
        used       = 5'b00010;
        flags      = {word.bypass, word.mask, word.loopback, word.acc_op};
      end
      INST_LOADMAC: begin
        inst       = INST_LOADMAC;
        addr.xy_rd = word.a;
        addr.mac   = word.b;
        used       = 5'b10001;
      end
      INST_MATMULT: begin
        inst       = INST_MATMULT;
        addr.w_rd  = word.a;
        addr.xy_rd = word.b;
        addr.xy_wr = word.c;
        used       = 5'b00111;
        flags      = {word.bypass, word.mask, word.loopback, word.acc_op};
      end
      INST_VECTTOMAT: begin
        inst       = INST_VECTTOMAT;
        addr.xy_rd = word.a;
        addr.w_wr  = word.b;
        used       = 5'b01001;
      end
      INST_WACC: begin
        inst      = INST_WACC;
        addr.w_rd = word.a;
        addr.w_wr = word.b;
        used      = 5'b01100;
      end
      INST_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // NOP and rpt==0 both issue exactly once.
  always_comb begin
    if ((word.op == 4'h0) || (word.rpt == {RPT_W{1'b0}})) begin
      last_cnt = {RPT_W{1'b0}};
    end else begin
      last_cnt = word.rpt - {{(RPT_W - 1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/nn_sequencer.sv
// Program sequencer: fetches words from program memory, decodes them and
// issues them to the controller with optional repeat and stall handling.
module nn_sequencer
  import nn_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] pc_start,
  output logic            busy,
  output logic            halted,
  output logic            error,
  nn_sequencer_if.master  bus
);

  seq_state_t       state_r;
  logic [PC_W-1:0]  pc_r;
  logic [RPT_W-1:0] cnt_r;
  logic [RPT_W-1:0] last_r;
  logic [4:0]       used_r;
  logic             prog_rd_en_r;
  logic [PC_W-1:0]  prog_addr_r;
  logic             issue_valid_r;
  inst_t            inst_r;
  seq_addr_t        addr_r;
  logic [3:0]       flags_r;
  logic             busy_r;
  logic             halted_r;
  logic             error_r;

  seq_word_t        word_s;
  inst_t            dec_inst_s;
  seq_addr_t        dec_addr_s;
  logic [4:0]       dec_used_s;
  logic [3:0]       dec_flags_s;
  logic [RPT_W-1:0] dec_last_s;
  logic             dec_legal_s;
  logic             dec_halt_s;

  assign word_s = seq_word_t'(bus.prog_data);

  nn_sequencer_decode u_decode (
    .word     (word_s),
    .inst     (dec_inst_s),
    .addr     (dec_addr_s),
    .used     (dec_used_s),
    .flags    (dec_flags_s),
    .last_cnt (dec_last_s),
    .legal    (dec_legal_s),
    .is_halt  (dec_halt_s)
  );

  // Sequencer FSM; every bus output is a register so prog_data never reaches an output combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      pc_r          <= {PC_W{1'b0}};
      cnt_r         <= {RPT_W{1'b0}};
      last_r        <= {RPT_W{1'b0}};
      used_r        <= 5'b00000;
      prog_rd_en_r  <= 1'b0;
      prog_addr_r   <= {PC_W{1'b0}};
      issue_valid_r <= 1'b0;
      inst_r        <= INST_NOP;
      addr_r        <= ADDR_NONE;
      flags_r       <= 4'b0000;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE, HALTED: begin
          if (start) begin
            state_r      <= FETCH;
            pc_r         <= pc_start;
            prog_addr_r  <= pc_start;
            prog_rd_en_r <= 1'b1;
            error_r      <= 1'b0;
            busy_r       <= 1'b1;
            halted_r     <= 1'b0;
          end
        end
        FETCH: begin
          prog_rd_en_r <= 1'b0;
          state_r      <= LOAD;
        end
        LOAD: begin
          cnt_r  <= {RPT_W{1'b0}};
          last_r <= dec_last_s;
          used_r <= dec_used_s;
          if (!dec_legal_s || dec_halt_s) begin
            error_r  <= !dec_legal_s;
            state_r  <= HALTED;
            halted_r <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            state_r       <= ISSUE;
            issue_valid_r <= 1'b1;
            inst_r        <= dec_inst_s;
            addr_r        <= dec_addr_s;
            flags_r       <= dec_flags_s;
          end
        end
        ISSUE: begin
          // A stalled cycle leaves every issue register untouched.
          if (!bus.stall) begin
            if (cnt_r == last_r) begin
              pc_r          <= pc_r + {{(PC_W - 1){1'b0}}, 1'b1};
              prog_addr_r   <= pc_r + {{(PC_W - 1){1'b0}}, 1'b1};
              prog_rd_en_r  <= 1'b1;
              state_r       <= FETCH;
              issue_valid_r <= 1'b0;
              inst_r        <= INST_NOP;
              addr_r        <= ADDR_NONE;
              flags_r       <= 4'b0000;
            end else begin
              cnt_r        <= cnt_r + {{(RPT_W - 1){1'b0}}, 1'b1};
              addr_r.xy_rd <= bump(addr_r.xy_rd, used_r[USE_XY_RD]);
              addr_r.xy_wr <= bump(addr_r.xy_wr, used_r[USE_XY_WR]);
              addr_r.w_rd  <= bump(addr_r.w_rd,  used_r[USE_W_RD]);
              addr_r.w_wr  <= bump(addr_r.w_wr,  used_r[USE_W_WR]);
              addr_r.mac   <= bump(addr_r.mac,   used_r[USE_MAC]);
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          prog_rd_en_r  <= 1'b0;
          issue_valid_r <= 1'b0;
          inst_r        <= INST_NOP;
          addr_r        <= ADDR_NONE;
          flags_r       <= 4'b0000;
          busy_r        <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_rd_en      = prog_rd_en_r;
  assign bus.prog_addr       = prog_addr_r;
  assign bus.issue_valid     = issue_valid_r;
  assign bus.instruction     = inst_r;
  assign bus.xy_read_addr    = addr_r.xy_rd;
  assign bus.xy_write_addr   = addr_r.xy_wr;
  assign bus.w_read_addr     = addr_r.w_rd;
  assign bus.w_write_addr    = addr_r.w_wr;
  assign bus.mac_addr        = addr_r.mac;
  assign bus.act_bypass      = flags_r[3];
  assign bus.act_mask        = flags_r[2];
  assign bus.xy_acc_loopback = flags_r[1];
  assign bus.xy_acc_op       = flags_r[0];
  assign busy                = busy_r;
  assign halted              = halted_r;
  assign error               = error_r;

endmodule

// File: tb/tb_nn_sequencer.sv
// Scoreboard bench for nn_sequencer: a program-level reference model queues
// expected issues and fetch addresses; a negedge monitor compares them.
module tb_nn_sequencer;
  import nn_sequencer_pkg::*;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] xy_rd;
    logic [15:0] xy_wr;
    logic [15:0] w_rd;
    logic [15:0] w_wr;
    logic [15:0] mac;
    logic [3:0]  flags;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] pc_start = '0;
  logic            busy, halted, error;

  nn_sequencer_if bus ();

  nn_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pc_start (pc_start),
    .busy     (busy),
    .halted   (halted),
    .error    (error),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  logic [63:0] prog_mem [0:1023];
  exp_t        exp_q[$];
  int          fetch_q[$];
  int          checks = 0;
  int          errors = 0;
  int          valid_cycles = 0;
  bit          stall_rand = 1'b0;
  bit          stall_force = 1'b0;
  exp_t        got;

  always @(posedge clk) if (bus.prog_rd_en) bus.prog_data <= prog_mem[bus.prog_addr];

  initial begin
    bus.stall = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.stall = stall_force | (stall_rand & ($urandom_range(0, 2) == 0));
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [7:0] rpt, input logic [3:0] f);
    return {op, a, b, c, rpt, f};
  endfunction

  // Expected controller view of the k-th repetition of word w.
  function automatic exp_t model(input logic [63:0] w, input int k);
    exp_t        e = '0;
    logic [15:0] a, b, c;
    a = w[59:44] + 16'(k);
    b = w[43:28] + 16'(k);
    c = w[27:12] + 16'(k);
    e.op = w[63:60];
    case (w[63:60])
      4'h1, 4'h6: begin e.xy_rd = a; e.w_rd = b; end
      4'h2:       begin e.xy_wr = a; e.flags = w[3:0]; end
      4'h3:       begin e.xy_rd = a; e.mac = b; end
      4'h4:       begin e.w_rd = a; e.xy_rd = b; e.xy_wr = c; e.flags = w[3:0]; end
      4'h5:       begin e.xy_rd = a; e.w_wr = b; end
      4'h7:       begin e.w_rd = a; e.w_wr = b; end
      default:    ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      got = {bus.instruction, bus.xy_read_addr, bus.xy_write_addr, bus.w_read_addr,
             bus.w_write_addr, bus.mac_addr, bus.act_bypass, bus.act_mask,
             bus.xy_acc_loopback, bus.xy_acc_op};
      if (bus.issue_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) chk("unexpected_issue", got, 128'd0);
        else begin
          chk("issue", got, exp_q[0]);
          if (!bus.stall) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_outputs", got, 128'd0);
      end
      if (bus.prog_rd_en) begin
        if (fetch_q.size() == 0) chk("unexpected_fetch", bus.prog_addr, 128'hFFFF);
        else chk("fetch_addr", bus.prog_addr, fetch_q.pop_front());
      end
    end
  end

  // Run the program at pcs to completion; stall_on>0 stalls two cycles from that cycle.
  task automatic run_prog(input int pcs, input bit chk_lat, input bit poke, input int stall_on);
    int pc = pcs;
    int cyc = 0;
    int n = 0;
    int rep;
    bit exp_err = 1'b0;
    bit done = 1'b0;
    logic [63:0] w;
    for (int i = 0; i < 64; i++) begin
      w = prog_mem[pc];
      fetch_q.push_back(pc);
      if (w[63:60] == 4'h8) break;
      if (w[63:60] > 4'h8) begin exp_err = 1'b1; break; end
      rep = (w[63:60] == 4'h0 || w[11:4] == 8'd0) ? 1 : int'(w[11:4]);
      for (int k = 0; k < rep; k++) exp_q.push_back(model(w, k));
      cyc += 2 + rep;
      pc = (pc + 1) % 1024;
    end
    cyc += 2;
    if (stall_on > 0) cyc += 2;
    valid_cycles = 0;
    @(posedge clk); #1;
    start = 1'b1;
    pc_start = PC_W'(pcs);
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk("error_cleared_on_start", error, 1'b0);
        chk("busy_after_start", busy, 1'b1);
      end
      if (poke && n == 3) begin start = 1'b1; pc_start = PC_W'($urandom); end
      if (poke && n == 4) start = 1'b0;
      if (stall_on > 0 && n == stall_on) stall_force = 1'b1;
      if (stall_on > 0 && n == stall_on + 2) stall_force = 1'b0;
      if (halted) done = 1'b1;
    end
    if (!done) begin
      chk("halt_timeout", 1'b0, 1'b1);
      exp_q.delete();
      fetch_q.delete();
    end else begin
      if (chk_lat) chk("halt_latency", n - 1, cyc);
      chk("error_flag", error, exp_err);
      chk("busy_when_halted", busy, 1'b0);
      chk("issues_drained", exp_q.size(), 0);
      chk("fetches_drained", fetch_q.size(), 0);
    end
  endtask

  initial begin
    int pcs, ni;
    for (int i = 0; i < 1024; i++) prog_mem[i] = {4'h8, 60'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_issue_valid", bus.issue_valid, 1'b0);
    chk("rst_instruction", bus.instruction, INST_NOP);
    chk("rst_prog_rd_en", bus.prog_rd_en, 1'b0);
    chk("rst_flags", {busy, halted, error}, 3'b000);
    @(negedge clk) reset = 1'b1;

    // Single MATMUL, rpt=0
    prog_mem[4] = mk(4'h1, 16'd4, 16'd4, 16'd0, 8'd0, 4'h0);
    run_prog(4, 1'b1, 1'b0, 0);
    chk("t1_issue_count", valid_cycles, 1);

    // MATMULT with repeat 3 and flags
    prog_mem[8] = mk(4'h4, 16'd8, 16'd2, 16'd16, 8'd3, 4'b1100);
    run_prog(8, 1'b1, 1'b0, 0);
    chk("t2_issue_count", valid_cycles, 3);

    // Same, stalled two cycles on the second issue
    run_prog(8, 1'b1, 1'b0, 4);
    chk("t3_valid_cycles", valid_cycles, 5);

    // PC wrap from 1023 to 0
    prog_mem[1023] = mk(4'h2, 16'd7, 16'd0, 16'd0, 8'd0, 4'h0);
    run_prog(1023, 1'b1, 1'b0, 0);

    // Illegal opcode, then a clean restart
    prog_mem[200] = mk(4'hF, 16'd1, 16'd2, 16'd3, 8'd2, 4'h0);
    run_prog(200, 1'b1, 1'b0, 0);
    chk("t5_no_issue", valid_cycles, 0);
    run_prog(4, 1'b1, 1'b0, 0);

    // Address wrap on repeat, NOP ignoring rpt
    prog_mem[300] = mk(4'h7, 16'hFFFE, 16'h0010, 16'h0, 8'd4, 4'h0);
    prog_mem[301] = mk(4'h0, 16'd5, 16'd5, 16'd5, 8'd7, 4'hF);
    run_prog(300, 1'b1, 1'b0, 0);
    chk("wrap_valid_cycles", valid_cycles, 5);

    // Async reset in the middle of a repeated issue
    prog_mem[100] = mk(4'h1, 16'd1, 16'd2, 16'd0, 8'd5, 4'h0);
    fetch_q.push_back(100);
    for (int k = 0; k < 5; k++) exp_q.push_back(model(prog_mem[100], k));
    @(posedge clk); #1;
    start = 1'b1;
    pc_start = PC_W'(100);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_issue_valid", bus.issue_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t6_issue_valid", bus.issue_valid, 1'b0);
    chk("t6_instruction", bus.instruction, INST_NOP);
    chk("t6_busy", busy, 1'b0);
    exp_q.delete();
    fetch_q.delete();
    @(negedge clk) reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_idle_after_reset", {busy, halted, bus.prog_rd_en, bus.issue_valid}, 4'b0000);

    // Randomized programs
    for (int r = 0; r < 24; r++) begin
      pcs = $urandom_range(0, 1023);
      ni  = $urandom_range(1, 5);
      for (int j = 0; j < ni; j++)
        prog_mem[(pcs + j) % 1024] = mk(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                                        16'($urandom), 8'($urandom_range(0, 4)), 4'($urandom));
      if ($urandom_range(0, 5) == 0) prog_mem[(pcs + ni) % 1024] = mk(4'($urandom_range(9, 15)), 16'd0, 16'd0, 16'd0, 8'd0, 4'h0);
      else prog_mem[(pcs + ni) % 1024] = {4'h8, 60'h0};
      stall_rand = (r % 2) == 1;
      run_prog(pcs, !stall_rand, 1'b1, 0);
      stall_rand = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
